// File: rtl/instr_stream_loader.sv
// Serialises 32-bit instruction words into a framed byte stream (0xFE, data MSB first, 0xFF)
// for the instruction memory byte-load port. One session per reset.
module instr_stream_loader #(
    parameter int unsigned MAX_WORDS = 64,
    parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [6:0]  num_words_i,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    output logic [7:0]  instr_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        underrun_o,
    output logic        ff_sub_o
);

    localparam logic [7:0] START_BYTE = 8'hFE;
    localparam logic [7:0] STOP_BYTE  = 8'hFF;
    localparam logic [6:0] MAX_N      = 7'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // 0xFF inside the data would end the frame at the receiver, so it goes out as 0x00.
    function automatic logic [7:0] sub_ff(input logic [7:0] data_byte);
        if (data_byte == STOP_BYTE) begin
            return 8'h00;
        end else begin
            return data_byte;
        end
    endfunction

    function automatic logic legal_count(input logic [6:0] count);
        return (count != 7'd0) && (count <= MAX_N);
    endfunction

    state_t      state_r, state_s;
    logic [31:0] slot0_r, slot1_r;
    logic        slot0_full_r, slot1_full_r;
    logic [1:0]  byte_idx_r;
    logic [6:0]  n_r, acc_cnt_r, sent_cnt_r;
    logic [7:0]  instr_r;
    logic        busy_r, done_r, underrun_r, ff_sub_r;

    logic        boundary_s, more_s, advance_s, starve_s, active_s;
    logic        ready_s, take_s, busy_s;
    logic [7:0]  cur_byte_s;

    // Handshake and word-boundary decode, all from registered state.
    always_comb begin
        boundary_s = (state_r == S_DATA) && (byte_idx_r == 2'd0);
        more_s     = sent_cnt_r < n_r;
        advance_s  = boundary_s && more_s && slot1_full_r;
        starve_s   = boundary_s && more_s && !slot1_full_r;
        active_s   = (state_r == S_FILL) || (state_r == S_START) || (state_r == S_DATA);
        ready_s    = active_s && (!slot1_full_r || boundary_s) && (acc_cnt_r < n_r);
        take_s     = ready_s && word_valid_i;
        cur_byte_s = slot0_r[{byte_idx_r, 3'b000} +: 8];
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_i && legal_count(num_words_i)) begin
                    state_s = S_FILL;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FILL: begin
                if (slot0_full_r) begin
                    state_s = S_START;
                end else begin
                    state_s = S_FILL;
                end
            end
            S_START: state_s = S_DATA;
            S_DATA: begin
                if (boundary_s && !advance_s) begin
                    state_s = S_STOP;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_STOP:  state_s = S_DONE;
            S_DONE:  state_s = S_DONE;
            default: state_s = S_IDLE;
        endcase
        busy_s = (state_s == S_FILL) || (state_s == S_START) ||
                 (state_s == S_DATA) || (state_s == S_STOP);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Double buffer, byte index and session counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot0_r      <= 32'h0000_0000;
            slot1_r      <= 32'h0000_0000;
            slot0_full_r <= 1'b0;
            slot1_full_r <= 1'b0;
            byte_idx_r   <= 2'd0;
            n_r          <= 7'd0;
            acc_cnt_r    <= 7'd0;
            sent_cnt_r   <= 7'd0;
        end else begin
            if ((state_r == S_IDLE) && start_i && legal_count(num_words_i)) begin
                n_r <= num_words_i;
            end
            if (take_s) begin
                acc_cnt_r <= acc_cnt_r + 7'd1;
            end
            // slot1 may drain into slot0 and refill from the source on the same edge.
            if (advance_s) begin
                slot0_r      <= slot1_r;
                sent_cnt_r   <= sent_cnt_r + 7'd1;
                slot1_full_r <= take_s;
                if (take_s) begin
                    slot1_r <= word_i;
                end
            end else if (take_s) begin
                if (!slot0_full_r) begin
                    slot0_r      <= word_i;
                    slot0_full_r <= 1'b1;
                    sent_cnt_r   <= sent_cnt_r + 7'd1;
                end else begin
                    slot1_r      <= word_i;
                    slot1_full_r <= 1'b1;
                end
            end
            if (state_r == S_START) begin
                byte_idx_r <= 2'd3;
            end else if (state_r == S_DATA) begin
                byte_idx_r <= byte_idx_r - 2'd1;
            end
        end
    end

    // Registered stream byte and status flags; the flags are sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_r    <= IDLE_BYTE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            underrun_r <= 1'b0;
            ff_sub_r   <= 1'b0;
        end else begin
            case (state_r)
                S_START: instr_r <= START_BYTE;
                S_DATA:  instr_r <= sub_ff(cur_byte_s);
                S_STOP:  instr_r <= STOP_BYTE;
                default: instr_r <= IDLE_BYTE;
            endcase
            busy_r <= busy_s;
            if ((state_r == S_DATA) && (cur_byte_s == STOP_BYTE)) begin
                ff_sub_r <= 1'b1;
            end
            if (starve_s) begin
                underrun_r <= 1'b1;
            end
            if (state_r == S_STOP) begin
                done_r <= 1'b1;
            end
        end
    end

    assign word_ready_o = ready_s;
    assign instr_o      = instr_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign underrun_o   = underrun_r;
    assign ff_sub_o     = ff_sub_r;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Scoreboard bench for instr_stream_loader: a timeline model predicts each session's frame,
// flags and handshake count; a negedge monitor compares the byte stream against the queue.
module tb_instr_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [6:0]  num_words_i;
    logic [31:0] word_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic [7:0]  instr_o;
    logic        busy_o, done_o, underrun_o, ff_sub_o;

    instr_stream_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .num_words_i  (num_words_i),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .instr_o      (instr_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .underrun_o   (underrun_o),
        .ff_sub_o     (ff_sub_o)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          hs_cnt = 0;
    int          fe_cyc = 0;
    bit          in_frame = 1'b0;
    logic [7:0]  mon_e;
    logic [7:0]  exp_q[$];
    logic [31:0] w_a[64];
    int          gap_a[64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stream monitor: a frame opens on 0xFE and every byte until the expected 0xFF is compared.
    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
        end else if (in_frame || instr_o == 8'hFE) begin
            if (!in_frame) fe_cyc = cyc;
            in_frame = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stream_extra actual=%0h required=no_byte", instr_o);
                in_frame = 1'b0;
            end else begin
                mon_e = exp_q.pop_front();
                check("stream_byte", {24'h0, instr_o}, {24'h0, mon_e});
                if (mon_e == 8'hFF) in_frame = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && word_valid_i && word_ready_o) hs_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int r;
        for (int b = 0; b < 4; b++) begin
            r = $urandom_range(0, 7);
            if (r == 0)      w[8*b +: 8] = 8'hFF;
            else if (r == 1) w[8*b +: 8] = 8'hFE;
            else             w[8*b +: 8] = 8'($urandom_range(0, 255));
        end
        return w;
    endfunction

    task automatic do_reset();
        reset        = 1'b1;
        start_i      = 1'b0;
        word_valid_i = 1'b0;
        num_words_i  = 7'd0;
        word_i       = 32'h0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_done);
        check({tag, "_instr"}, {24'h0, instr_o}, 32'h00);
        check({tag, "_ready"}, {31'h0, word_ready_o}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
        check({tag, "_done"}, {31'h0, done_o}, {31'h0, exp_done});
    endtask

    // Model: word k must be accepted strictly before the boundary edge of word k-1.
    task automatic run_session(input int n, input int abort_at);
        int t, next_vis, idx, hs0, e1, a_prev, a_k, dl, sent, hs_exp;
        bit und, ffs, hs, dn, aborted;
        logic [7:0] bt;
        e1 = (gap_a[0] < 1) ? 1 : gap_a[0];
        a_prev = e1; sent = n; hs_exp = n; und = 1'b0; ffs = 1'b0;
        for (int k = 1; k < n; k++) begin
            a_k = a_prev + 1 + gap_a[k];
            if (k >= 2 && a_k < e1 + 2 + 4 * (k - 1)) a_k = e1 + 2 + 4 * (k - 1);
            dl = e1 + 2 + 4 * k;
            if (a_k >= dl) begin
                und = 1'b1; sent = k; hs_exp = (a_k == dl) ? k + 1 : k;
                break;
            end
            a_prev = a_k;
        end
        exp_q.push_back(8'hFE);
        for (int i = 0; i < sent; i++) begin
            for (int b = 3; b >= 0; b--) begin
                bt = w_a[i][8*b +: 8];
                if (bt == 8'hFF) begin
                    ffs = 1'b1;
                    exp_q.push_back(8'h00);
                end else begin
                    exp_q.push_back(bt);
                end
            end
        end
        exp_q.push_back(8'hFF);

        hs0 = hs_cnt;
        @(posedge clk); #1;
        start_i = 1'b1; num_words_i = 7'(n);
        t = cyc + 1; next_vis = t + gap_a[0]; idx = 0; aborted = 1'b0; dn = 1'b0;
        for (int c = 0; c < 1200 && !dn && !aborted; c++) begin
            if (!word_valid_i && idx < n && cyc + 1 >= next_vis) begin
                word_i = w_a[idx]; word_valid_i = 1'b1;
            end
            @(negedge clk);
            hs = word_valid_i && word_ready_o;
            dn = done_o;
            if (abort_at > 0 && cyc - t >= abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_instr", {24'h0, instr_o}, 32'h00);
                check("abort_busy", {31'h0, busy_o}, 32'h0);
                check("abort_done", {31'h0, done_o}, 32'h0);
                check("abort_underrun", {31'h0, underrun_o}, 32'h0);
                check("abort_ffsub", {31'h0, ff_sub_o}, 32'h0);
                check("abort_ready", {31'h0, word_ready_o}, 32'h0);
                aborted = 1'b1;
            end else if (!dn) begin
                @(posedge clk); #1;
                start_i = 1'b0;
                if (hs) begin
                    word_valid_i = 1'b0;
                    idx++;
                    if (idx < n) next_vis = cyc + 1 + gap_a[idx];
                end
            end
        end
        start_i = 1'b0;
        word_valid_i = 1'b0;
        if (aborted) begin
            do_reset();
        end else begin
            if (!dn) begin
                checks++; failures++;
                $display("FAIL session_timeout actual=no_done required=done n=%0d", n);
            end
            repeat (2) @(negedge clk);
            check("end_underrun", {31'h0, underrun_o}, {31'h0, und});
            check("end_ffsub", {31'h0, ff_sub_o}, {31'h0, ffs});
            check("end_handshakes", hs_cnt - hs0, hs_exp);
            check("end_fe_latency", fe_cyc - t, e1 + 2);
            check("end_queue_left", exp_q.size(), 0);
            check_idle_outputs("end", 1'b1);
        end
    endtask

    task automatic set_all_valid(input int n);
        for (int i = 0; i < 64; i++) gap_a[i] = 0;
        for (int i = 0; i < n; i++) w_a[i] = rand_word();
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; word_valid_i = 1'b0;
        num_words_i = 7'd0; word_i = 32'h0;
        #2;
        check("rst_underrun", {31'h0, underrun_o}, 32'h0);
        check("rst_ffsub", {31'h0, ff_sub_o}, 32'h0);
        check_idle_outputs("rst", 1'b0);
        do_reset();

        // Two words, always-valid source.
        set_all_valid(2);
        w_a[0] = 32'h0000_0013; w_a[1] = 32'h00A0_0093;
        run_session(2, 0);

        // start_i after done_o is ignored.
        @(posedge clk); #1;
        start_i = 1'b1; num_words_i = 7'd1; word_i = 32'h1234_5678; word_valid_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("post_done", 1'b1);
        end
        word_valid_i = 1'b0;

        // 0xFF substitution and 0xFE pass-through.
        do_reset();
        set_all_valid(1);
        w_a[0] = 32'hFFFE_0001;
        run_session(1, 0);

        // Source starves on word 2.
        do_reset();
        set_all_valid(3);
        gap_a[1] = 10;
        run_session(3, 0);

        // Illegal counts leave the loader idle.
        do_reset();
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            start_i = 1'b1; num_words_i = (j == 0) ? 7'd0 : 7'd65;
            word_i = rand_word(); word_valid_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            repeat (2) begin
                @(negedge clk);
                check_idle_outputs("illegal", 1'b0);
            end
            word_valid_i = 1'b0;
        end
        set_all_valid(1);
        run_session(1, 0);

        // Reset during DATA, then a clean session.
        do_reset();
        set_all_valid(4);
        run_session(4, 8);
        set_all_valid(1);
        run_session(1, 0);

        // Largest legal session.
        do_reset();
        set_all_valid(64);
        run_session(64, 0);

        // Random sessions with random source gaps.
        for (int s = 0; s < 12; s++) begin
            int n, r;
            do_reset();
            n = $urandom_range(1, 8);
            set_all_valid(n);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                if (r < 6)      gap_a[i] = 0;
                else if (r < 9) gap_a[i] = $urandom_range(1, 3);
                else            gap_a[i] = $urandom_range(4, 12);
            end
            run_session(n, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
